// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for pipelined_addsub.
// The master drives the operands; the adder drives the registered results.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
);
  localparam int unsigned STAGES = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int unsigned CW     = $clog2(STAGES + 1);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;
  logic             out_valid;
  logic [CW-1:0]    in_flight;

  modport master (
    output in_valid, a, b, cin, sub,
    input  s, cout, overflow, out_valid, in_flight
  );

  modport slave (
    input  in_valid, a, b, cin, sub,
    output s, cout, overflow, out_valid, in_flight
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Digit-serial pipelined adder/subtractor: stage k resolves DIGIT bits and
// hands its carry to stage k+1; operands and partial sums travel in lockstep.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  pipelined_addsub_if.slave  bus
);
  localparam int unsigned STAGES = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int unsigned CW     = $clog2(STAGES + 1);

  // Ripple bits [lo, hi) into the running sum; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] digit_add(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] sin,
    input logic             ci,
    input int unsigned      lo,
    input int unsigned      hi
  );
    logic [WIDTH-1:0] sum;
    logic             c;
    sum = sin;
    c   = ci;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i >= lo && i < hi) begin
        sum[i] = x[i] ^ y[i] ^ c;
        c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
    end
    return {c, sum};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO = k * DIGIT;
    localparam int unsigned HI = (k == STAGES - 1) ? WIDTH : LO + DIGIT;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] s_d;
    logic             c_d;
    logic             v_d;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_src
      assign a_d = bus.a;
      assign b_d = bus.sub ? ~bus.b : bus.b;
      assign s_d = '0;
      assign c_d = bus.cin;
      assign v_d = bus.in_valid;
    end else begin : g_src
      assign a_d = g_stg[k-1].g_fwd.a_q;
      assign b_d = g_stg[k-1].g_fwd.b_q;
      assign s_d = g_stg[k-1].s_q;
      assign c_d = g_stg[k-1].c_q;
      assign v_d = g_stg[k-1].v_q;
    end

    assign r = digit_add(a_d, b_d, s_d, c_d, LO, HI);

    // Partial sum, carry and valid tag for this stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= r[WIDTH-1:0];
        c_q <= r[WIDTH];
        v_q <= v_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ov_q;

      // Carry into the MSB equals a^b'^s at that bit, so overflow needs no extra tap.
      always_ff @(posedge clk) begin
        if (rst) begin
          ov_q <= 1'b0;
        end else if (en) begin
          ov_q <= a_d[WIDTH-1] ^ b_d[WIDTH-1] ^ r[WIDTH-1] ^ r[WIDTH];
        end
      end
    end
  end

  logic          out_v;
  logic [CW-1:0] cnt_q;

  assign out_v = g_stg[STAGES-1].v_q;

  // Population of valid tags: one in per accepted token, one out per delivered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(bus.in_valid) - CW'(out_v);
    end
  end

  assign bus.s         = g_stg[STAGES-1].s_q;
  assign bus.cout      = g_stg[STAGES-1].c_q;
  assign bus.overflow  = g_stg[STAGES-1].g_last.ov_q;
  assign bus.out_valid = out_v;
  assign bus.in_flight = cnt_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: an 8-bit/2-bit-digit instance and a
// ragged 7-bit/3-bit-digit instance sharing clock, reset and enable.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(8), .DIGIT(2)) bus8 ();
  pipelined_addsub_if #(.WIDTH(7), .DIGIT(3)) bus7 ();

  pipelined_addsub #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst(rst), .en(en), .bus(bus8));
  pipelined_addsub #(.WIDTH(7), .DIGIT(3)) dut7 (.clk(clk), .rst(rst), .en(en), .bus(bus7));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb);
    bus8.in_valid = v;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = ci;
    bus8.sub      = sb;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b1;
    for (int n = 0; n < 2; n++) begin
      drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      bus7.in_valid = 1'b1;
      bus7.a        = 7'($urandom);
      bus7.b        = 7'($urandom);
      bus7.cin      = 1'($urandom);
      bus7.sub      = 1'($urandom);
      tick();
      checks++;
      if (bus8.s !== 8'h00 || bus8.cout !== 1'b0 || bus8.overflow !== 1'b0 ||
          bus8.out_valid !== 1'b0 || bus8.in_flight !== 3'd0) begin
        errors++;
        $display("FAIL reset8: s=%h cout=%b ovf=%b out_valid=%b in_flight=%0d, required all zero",
                 bus8.s, bus8.cout, bus8.overflow, bus8.out_valid, bus8.in_flight);
      end
      checks++;
      if (bus7.s !== 7'h00 || bus7.cout !== 1'b0 || bus7.overflow !== 1'b0 ||
          bus7.out_valid !== 1'b0 || bus7.in_flight !== 2'd0) begin
        errors++;
        $display("FAIL reset7: s=%h cout=%b ovf=%b out_valid=%b in_flight=%0d, required all zero",
                 bus7.s, bus7.cout, bus7.overflow, bus7.out_valid, bus7.in_flight);
      end
    end
    rst = 1'b0;
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus7.in_valid = 1'b0;
    bus7.a        = '0;
    bus7.b        = '0;
    bus7.cin      = 1'b0;
    bus7.sub      = 1'b0;
  endtask

  task automatic test_add;
    drive8(1'b1, 8'd200, 8'd100, 1'b0, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 1) drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      checks++;
      if (bus8.out_valid !== (e == 4) || bus8.in_flight !== ((e <= 4) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL add_timing edge %0d: out_valid=%b in_flight=%0d, required %b / %0d",
                 e, bus8.out_valid, bus8.in_flight, (e == 4), (e <= 4) ? 1 : 0);
      end
      if (e == 4) begin
        checks++;
        if (bus8.s !== 8'h2C || bus8.cout !== 1'b1 || bus8.overflow !== 1'b0) begin
          errors++;
          $display("FAIL add_result: s=%h cout=%b ovf=%b, required 2c 1 0",
                   bus8.s, bus8.cout, bus8.overflow);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_s [2];
    logic       exp_o [2];
    int         got;
    exp_s[0] = 8'hFE; exp_o[0] = 1'b0;
    exp_s[1] = 8'h80; exp_o[1] = 1'b1;
    got = 0;
    drive8(1'b1, 8'd5, 8'd7, 1'b1, 1'b1);
    tick();
    drive8(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int cyc = 3; cyc <= 12; cyc++) begin
      tick();
      if (bus8.out_valid === 1'b1) begin
        if (got < 2) begin
          checks++;
          if (bus8.s !== exp_s[got] || bus8.cout !== 1'b0 || bus8.overflow !== exp_o[got] ||
              cyc != 4 + got) begin
            errors++;
            $display("FAIL b2b_result %0d: s=%h cout=%b ovf=%b edge=%0d, required %h 0 %b edge %0d",
                     got, bus8.s, bus8.cout, bus8.overflow, cyc, exp_s[got], exp_o[got], 4 + got);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL b2b_count: results=%0d, required 2", got);
    end
  endtask

  task automatic test_stall;
    logic [7:0] exp_s [4];
    int         got;
    int         peak;
    logic       stalled;
    got  = 0;
    peak = 0;
    for (int i = 0; i < 4; i++) exp_s[i] = 8'(2 * i + 3);
    for (int cyc = 0; cyc < 16; cyc++) begin
      stalled = (cyc >= 2 && cyc <= 4);
      en      = !stalled;
      case (cyc)
        0: drive8(1'b1, 8'd1, 8'd2, 1'b0, 1'b0);
        1: drive8(1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
        2, 3, 4: drive8(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);
        5: drive8(1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
        6: drive8(1'b1, 8'd4, 8'd5, 1'b0, 1'b0);
        default: drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      endcase
      tick();
      if (int'(bus8.in_flight) > peak) peak = int'(bus8.in_flight);
      if (stalled) begin
        checks++;
        if (bus8.in_flight !== 3'd2 || bus8.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold cyc %0d: in_flight=%0d out_valid=%b, required 2 0",
                   cyc, bus8.in_flight, bus8.out_valid);
        end
      end else if (bus8.out_valid === 1'b1) begin
        if (got < 4) begin
          checks++;
          if (bus8.s !== exp_s[got] || bus8.cout !== 1'b0 || bus8.overflow !== 1'b0) begin
            errors++;
            $display("FAIL stall_result %0d: s=%0d cout=%b ovf=%b, required %0d 0 0",
                     got, bus8.s, bus8.cout, bus8.overflow, exp_s[got]);
          end
        end
        got++;
      end
    end
    en = 1'b1;
    checks++;
    if (got != 4 || peak != 4) begin
      errors++;
      $display("FAIL stall_count: results=%0d peak=%0d, required 4 4", got, peak);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive8(1'b1, 8'(10 + i), 8'd1, 1'b0, 1'b0);
      tick();
    end
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus8.in_flight !== 3'd3) begin
      errors++;
      $display("FAIL midrst_pre: in_flight=%0d, required 3", bus8.in_flight);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_flight !== 3'd0) begin
      errors++;
      $display("FAIL midrst_post: out_valid=%b in_flight=%0d, required 0 0",
               bus8.out_valid, bus8.in_flight);
    end
    for (int n = 0; n < 8; n++) begin
      tick();
      if (bus8.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_ghost: out_valid cycles=%0d, required 0", seen);
    end
  endtask

  task automatic test_ragged;
    bus7.in_valid = 1'b1;
    bus7.a        = 7'h7F;
    bus7.b        = 7'h01;
    bus7.cin      = 1'b1;
    bus7.sub      = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e == 1) bus7.in_valid = 1'b0;
      checks++;
      if (bus7.out_valid !== (e == 3)) begin
        errors++;
        $display("FAIL ragged_timing edge %0d: out_valid=%b, required %b",
                 e, bus7.out_valid, (e == 3));
      end
    end
    checks++;
    if (bus7.s !== 7'h01 || bus7.cout !== 1'b1 || bus7.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ragged_result: s=%h cout=%b ovf=%b, required 01 1 0",
               bus7.s, bus7.cout, bus7.overflow);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_ragged();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
